// File: rtl/mnist_lut_pkg.sv
// Shared definitions for the MNIST LUT batch sequencer: FSM encoding and
// the one-hot-of-label helper used by the result checker.
package mnist_lut_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

    // Widest one-hot the helper can build; labels at or above this map to zero.
    localparam int unsigned ONEHOT_MAX = 256;

    function automatic logic [ONEHOT_MAX-1:0] onehot_of_label(input logic [31:0] label);
        logic [ONEHOT_MAX-1:0] v;
        v = '0;
        if (label < ONEHOT_MAX) begin
            v[label[7:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/mnist_lut_batch_sequencer_if.sv
// Sample-memory, network and result-sink signals of the batch sequencer.
interface mnist_lut_batch_sequencer_if #(
    parameter int unsigned USER_WIDTH   = 8,
    parameter int unsigned INPUT_WIDTH  = 784,
    parameter int unsigned OUTPUT_WIDTH = 10,
    parameter int unsigned ADDR_WIDTH   = 14
);
    logic                              mem_rd;
    logic [ADDR_WIDTH-1:0]             mem_addr;
    logic [USER_WIDTH+INPUT_WIDTH-1:0] mem_rdata;
    logic                              net_cke;
    logic [USER_WIDTH-1:0]             net_in_user;
    logic [INPUT_WIDTH-1:0]            net_in_data;
    logic                              net_in_valid;
    logic [USER_WIDTH-1:0]             net_out_user;
    logic [OUTPUT_WIDTH-1:0]           net_out_data;
    logic                              net_out_valid;
    logic                              res_ready;
    logic                              res_valid;
    logic [USER_WIDTH-1:0]             res_user;
    logic                              res_match;

    modport master (
        output mem_rd, mem_addr, net_cke, net_in_user, net_in_data, net_in_valid,
               res_valid, res_user, res_match,
        input  mem_rdata, net_out_user, net_out_data, net_out_valid, res_ready
    );

    modport slave (
        input  mem_rd, mem_addr, net_cke, net_in_user, net_in_data, net_in_valid,
               res_valid, res_user, res_match,
        output mem_rdata, net_out_user, net_out_data, net_out_valid, res_ready
    );
endinterface

// File: rtl/mnist_lut_result_checker.sv
// Compares each network result with its label and keeps the batch tallies.
module mnist_lut_result_checker
    import mnist_lut_pkg::*;
#(
    parameter int unsigned USER_WIDTH   = 8,
    parameter int unsigned OUTPUT_WIDTH = 10,
    parameter int unsigned ADDR_WIDTH   = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    net_cke,
    input  logic                    clear,
    input  logic                    net_out_valid,
    input  logic [USER_WIDTH-1:0]   net_out_user,
    input  logic [OUTPUT_WIDTH-1:0] net_out_data,
    output logic                    res_valid,
    output logic [USER_WIDTH-1:0]   res_user,
    output logic                    res_match,
    output logic [ADDR_WIDTH-1:0]   match_count,
    output logic [ADDR_WIDTH-1:0]   result_count
);

    logic [ONEHOT_MAX-1:0] expect_onehot;
    logic                  is_match;

    // Correct iff the label names a real class and the output is exactly its one-hot.
    always_comb begin
        expect_onehot = onehot_of_label(32'(net_out_user));
        is_match      = (32'(net_out_user) < OUTPUT_WIDTH) &&
                        (expect_onehot == {(ONEHOT_MAX-OUTPUT_WIDTH)'(0), net_out_data});
    end

    // Register one result per accepted network output; everything freezes without net_cke.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid    <= 1'b0;
            res_user     <= '0;
            res_match    <= 1'b0;
            match_count  <= '0;
            result_count <= '0;
        end else if (net_cke) begin
            res_valid <= net_out_valid;
            if (net_out_valid) begin
                res_user  <= net_out_user;
                res_match <= is_match;
            end
            if (clear) begin
                match_count  <= '0;
                result_count <= '0;
            end else if (net_out_valid) begin
                result_count <= result_count + ADDR_WIDTH'(1);
                if (is_match) begin
                    match_count <= match_count + ADDR_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/mnist_lut_batch_sequencer.sv
// Streams a batch of samples from memory through the LUT network and
// tallies how many results match their labels.
module mnist_lut_batch_sequencer
    import mnist_lut_pkg::*;
#(
    parameter int unsigned USER_WIDTH   = 8,
    parameter int unsigned INPUT_WIDTH  = 784,
    parameter int unsigned OUTPUT_WIDTH = 10,
    parameter int unsigned ADDR_WIDTH   = 14
) (
    input  logic                  reset,
    input  logic                  clk,
    input  logic                  cke,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] sample_count,
    output logic                  busy,
    output logic                  done,
    mnist_lut_batch_sequencer_if.master bus,
    output logic [ADDR_WIDTH-1:0] match_count,
    output logic [ADDR_WIDTH-1:0] result_count
);

    seq_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] count_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_next;
    logic [ADDR_WIDTH:0]   inflight_q;
    logic                  rd_pending_q;
    logic                  net_cke;
    logic                  mem_rd;
    logic                  accept_start;
    logic                  out_take;

    assign net_cke          = cke & bus.res_ready;
    assign bus.net_cke      = net_cke;
    assign bus.mem_rd       = mem_rd;
    assign bus.mem_addr     = addr_q;
    // Read data arrives the cycle after mem_rd and is held while mem_rd is low,
    // so the pending flag alone qualifies it as network input.
    assign bus.net_in_valid = rd_pending_q;
    assign bus.net_in_user  = bus.mem_rdata[USER_WIDTH+INPUT_WIDTH-1 -: USER_WIDTH];
    assign bus.net_in_data  = bus.mem_rdata[INPUT_WIDTH-1:0];
    assign out_take         = bus.net_out_valid && (inflight_q != '0);
    assign busy             = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done             = (state_q == ST_DONE);

    // Next-state and read-issue decode; nothing advances without net_cke.
    always_comb begin
        state_d      = state_q;
        accept_start = 1'b0;
        mem_rd       = 1'b0;
        addr_next    = addr_q + ADDR_WIDTH'(1);
        case (state_q)
            ST_IDLE: begin
                if (net_cke && start) begin
                    accept_start = 1'b1;
                    state_d      = (sample_count == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (net_cke) begin
                    mem_rd = 1'b1;
                    if (addr_next == count_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (net_cke && (inflight_q == '0) && !rd_pending_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (net_cke) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, issue address and in-flight bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            addr_q       <= '0;
            inflight_q   <= '0;
            rd_pending_q <= 1'b0;
        end else if (net_cke) begin
            state_q      <= state_d;
            rd_pending_q <= mem_rd;
            if (accept_start) begin
                count_q    <= sample_count;
                addr_q     <= '0;
                inflight_q <= '0;
            end else begin
                if (mem_rd) begin
                    addr_q <= addr_next;
                end
                case ({rd_pending_q, out_take})
                    2'b10:   inflight_q <= inflight_q + (ADDR_WIDTH+1)'(1);
                    2'b01:   inflight_q <= inflight_q - (ADDR_WIDTH+1)'(1);
                    default: inflight_q <= inflight_q;
                endcase
            end
        end
    end

    mnist_lut_result_checker #(
        .USER_WIDTH   (USER_WIDTH),
        .OUTPUT_WIDTH (OUTPUT_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_checker (
        .clk           (clk),
        .reset         (reset),
        .net_cke       (net_cke),
        .clear         (accept_start),
        .net_out_valid (out_take),
        .net_out_user  (bus.net_out_user),
        .net_out_data  (bus.net_out_data),
        .res_valid     (bus.res_valid),
        .res_user      (bus.res_user),
        .res_match     (bus.res_match),
        .match_count   (match_count),
        .result_count  (result_count)
    );

endmodule

// File: tb/tb_mnist_lut_batch_sequencer.sv
// Directed bench for the batch sequencer with a memory model and a
// 3-cycle delay-line network model.
module tb_mnist_lut_batch_sequencer;

    localparam int unsigned UW = 8;
    localparam int unsigned IW = 784;
    localparam int unsigned OW = 10;
    localparam int unsigned AW = 14;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cke = 1'b1;
    logic          start = 1'b0;
    logic          res_ready = 1'b1;
    logic [AW-1:0] sample_count = '0;
    logic          busy, done;
    logic [AW-1:0] match_count, result_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    mnist_lut_batch_sequencer_if #(
        .USER_WIDTH(UW), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .ADDR_WIDTH(AW)
    ) bus ();

    mnist_lut_batch_sequencer #(
        .USER_WIDTH(UW), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .ADDR_WIDTH(AW)
    ) dut (
        .reset        (reset),
        .clk          (clk),
        .cke          (cke),
        .start        (start),
        .sample_count (sample_count),
        .busy         (busy),
        .done         (done),
        .bus          (bus),
        .match_count  (match_count),
        .result_count (result_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sample memory: {label, pixel pattern derived from address}
    logic [UW-1:0] labels [0:15];
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= {labels[bus.mem_addr[3:0]], {98{bus.mem_addr[7:0]}}};
    end

    // Network: 3-stage delay line advancing on net_cke
    logic [2:0]    pv = '0;
    logic [UW-1:0] pu [0:2];
    logic [255:0]  corrupt = '0;

    function automatic logic [OW-1:0] model_class(input logic [UW-1:0] u, input logic [255:0] bad);
        logic [OW-1:0] r;
        int k;
        r = '0;
        k = int'(u);
        if (k < int'(OW)) begin
            if (bad[u]) r[(k + 1) % int'(OW)] = 1'b1;
            else        r[k] = 1'b1;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.net_cke) begin
            pv    <= {pv[1:0], bus.net_in_valid};
            pu[0] <= bus.net_in_user;
            pu[1] <= pu[0];
            pu[2] <= pu[1];
        end
    end
    assign bus.net_out_valid = pv[2];
    assign bus.net_out_user  = pu[2];
    assign bus.net_out_data  = model_class(pu[2], corrupt);
    assign bus.res_ready     = res_ready;

    // Event logs, sampled on the falling edge
    int rd_count = 0, nin_count = 0, res_count = 0, done_count = 0, busy_count = 0;
    int rd_base = 0, nin_base = 0, res_base = 0;
    int first_nin_cyc = 0, done_cyc = 0, res_at_done = 0;
    logic [AW-1:0] rd_addr_log  [0:31];
    logic [UW-1:0] nin_user_log [0:31];
    logic [IW-1:0] nin_pix_log  [0:31];
    logic [UW-1:0] res_user_log [0:31];
    logic          res_match_log[0:31];

    always @(negedge clk) begin
        if (bus.mem_rd) begin
            if (rd_count - rd_base < 32) rd_addr_log[5'(rd_count - rd_base)] <= bus.mem_addr;
            rd_count <= rd_count + 1;
        end
        if (bus.net_in_valid && bus.net_cke) begin
            if (nin_count - nin_base < 32) begin
                nin_user_log[5'(nin_count - nin_base)] <= bus.net_in_user;
                nin_pix_log[5'(nin_count - nin_base)]  <= bus.net_in_data;
            end
            if (nin_count == nin_base) first_nin_cyc <= cyc;
            nin_count <= nin_count + 1;
        end
        if (bus.res_valid && bus.net_cke) begin
            if (res_count - res_base < 32) begin
                res_user_log[5'(res_count - res_base)]  <= bus.res_user;
                res_match_log[5'(res_count - res_base)] <= bus.res_match;
            end
            res_count <= res_count + 1;
        end
        if (done && bus.net_cke) begin
            done_count  <= done_count + 1;
            done_cyc    <= cyc;
            res_at_done <= res_count - res_base;
        end
        if (busy) busy_count <= busy_count + 1;
    end

    task automatic pulse_start(input int n);
        @(posedge clk); #1;
        rd_base = rd_count; nin_base = nin_count; res_base = res_count;
        sample_count = AW'(n);
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done && bus.net_cke) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b expected 0", bus.mem_rd); end
        checks++; if (bus.mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %0d expected 0", bus.mem_addr); end
        checks++; if (bus.net_in_valid !== 1'b0) begin errors++; $display("FAIL reset_net_in_valid: got %b expected 0", bus.net_in_valid); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid); end
        checks++; if (bus.res_match !== 1'b0) begin errors++; $display("FAIL reset_res_match: got %b expected 0", bus.res_match); end
        checks++; if (bus.res_user !== '0) begin errors++; $display("FAIL reset_res_user: got %0d expected 0", bus.res_user); end
        checks++; if (match_count !== '0) begin errors++; $display("FAIL reset_match_count: got %0d expected 0", match_count); end
        checks++; if (result_count !== '0) begin errors++; $display("FAIL reset_result_count: got %0d expected 0", result_count); end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        logic [UW-1:0] lab [0:3];
        logic [7:0] ib;
        lab = '{8'd5, 8'd2, 8'd9, 8'd4};
        for (int i = 0; i < 4; i++) labels[i] = lab[i];
        pulse_start(4);
        wait_done(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done: got no done expected done within 60 cycles"); end
        checks++; if (rd_count - rd_base != 4) begin errors++; $display("FAIL basic_reads: got %0d expected 4", rd_count - rd_base); end
        for (int i = 0; i < 4; i++) begin
            ib = 8'(i);
            checks++; if (rd_addr_log[i] !== AW'(i)) begin errors++; $display("FAIL basic_addr[%0d]: got %0d expected %0d", i, rd_addr_log[i], i); end
            checks++; if (nin_user_log[i] !== lab[i]) begin errors++; $display("FAIL basic_in_user[%0d]: got %0d expected %0d", i, nin_user_log[i], lab[i]); end
            checks++; if (nin_pix_log[i] !== {98{ib}}) begin errors++; $display("FAIL basic_in_data[%0d]: got %h expected low byte %h", i, nin_pix_log[i][31:0], ib); end
        end
        checks++; if (first_nin_cyc - start_cyc != 2) begin errors++; $display("FAIL basic_latency: got %0d expected 2", first_nin_cyc - start_cyc); end
        checks++; if (res_at_done != 4) begin errors++; $display("FAIL basic_results_before_done: got %0d expected 4", res_at_done); end
        checks++; if (match_count !== AW'(4)) begin errors++; $display("FAIL basic_match_count: got %0d expected 4", match_count); end
        checks++; if (result_count !== AW'(4)) begin errors++; $display("FAIL basic_result_count: got %0d expected 4", result_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b expected 0", busy); end
        repeat (4) @(posedge clk);
    endtask

    task automatic test_zero();
        bit ok;
        int b0;
        b0 = busy_count;
        pulse_start(0);
        wait_done(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL zero_done: got no done expected done"); end
        checks++; if (done_cyc - start_cyc != 1) begin errors++; $display("FAIL zero_done_latency: got %0d expected 1", done_cyc - start_cyc); end
        repeat (2) @(negedge clk);
        checks++; if (busy_count != b0) begin errors++; $display("FAIL zero_busy: got %0d busy cycles expected 0", busy_count - b0); end
        checks++; if (rd_count != rd_base) begin errors++; $display("FAIL zero_reads: got %0d expected 0", rd_count - rd_base); end
        checks++; if (match_count !== '0) begin errors++; $display("FAIL zero_match_count: got %0d expected 0", match_count); end
        checks++; if (result_count !== '0) begin errors++; $display("FAIL zero_result_count: got %0d expected 0", result_count); end
    endtask

    task automatic test_mismatch();
        bit ok;
        logic [UW-1:0] lab [0:4];
        logic exp_m [0:4];
        lab = '{8'd7, 8'd3, 8'd12, 8'd1, 8'd0};
        exp_m = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) labels[i] = lab[i];
        corrupt = '0;
        corrupt[0] = 1'b1;
        pulse_start(5);
        wait_done(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mismatch_done: got no done expected done"); end
        checks++; if (res_count - res_base != 5) begin errors++; $display("FAIL mismatch_results: got %0d expected 5", res_count - res_base); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (res_match_log[i] !== exp_m[i]) begin errors++; $display("FAIL mismatch_res_match[%0d]: got %b expected %b", i, res_match_log[i], exp_m[i]); end
            checks++; if (res_user_log[i] !== lab[i]) begin errors++; $display("FAIL mismatch_res_user[%0d]: got %0d expected %0d", i, res_user_log[i], lab[i]); end
        end
        checks++; if (match_count !== AW'(3)) begin errors++; $display("FAIL mismatch_match_count: got %0d expected 3", match_count); end
        checks++; if (result_count !== AW'(5)) begin errors++; $display("FAIL mismatch_result_count: got %0d expected 5", result_count); end
        corrupt = '0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_stall();
        bit ok;
        bit hit;
        logic [AW-1:0] s_addr;
        logic          s_nin_v, s_res_v;
        logic [UW-1:0] s_nin_u, s_res_u;
        for (int i = 0; i < 6; i++) labels[i] = UW'(9 - i);
        pulse_start(6);
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (rd_count - rd_base >= 2) begin hit = 1'b1; break; end
        end
        checks++; if (!hit) begin errors++; $display("FAIL stall_issue_reached: got %0d reads expected 2", rd_count - rd_base); end
        res_ready = 1'b0;
        @(negedge clk);
        s_addr = bus.mem_addr; s_nin_v = bus.net_in_valid; s_nin_u = bus.net_in_user;
        s_res_v = bus.res_valid; s_res_u = bus.res_user;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            checks++; if (bus.net_cke !== 1'b0) begin errors++; $display("FAIL stall_net_cke[%0d]: got %b expected 0", c, bus.net_cke); end
            checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL stall_mem_rd[%0d]: got %b expected 0", c, bus.mem_rd); end
            if (c > 0) begin
                checks++; if (bus.mem_addr !== s_addr) begin errors++; $display("FAIL stall_mem_addr[%0d]: got %0d expected %0d", c, bus.mem_addr, s_addr); end
                checks++; if (bus.net_in_valid !== s_nin_v || bus.net_in_user !== s_nin_u) begin errors++; $display("FAIL stall_net_in[%0d]: got %b/%0d expected %b/%0d", c, bus.net_in_valid, bus.net_in_user, s_nin_v, s_nin_u); end
                checks++; if (bus.res_valid !== s_res_v || bus.res_user !== s_res_u) begin errors++; $display("FAIL stall_res[%0d]: got %b/%0d expected %b/%0d", c, bus.res_valid, bus.res_user, s_res_v, s_res_u); end
            end
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        wait_done(80, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_done: got no done expected done"); end
        checks++; if (rd_count - rd_base != 6) begin errors++; $display("FAIL stall_reads: got %0d expected 6", rd_count - rd_base); end
        checks++; if (nin_count - nin_base != 6) begin errors++; $display("FAIL stall_net_inputs: got %0d expected 6", nin_count - nin_base); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (rd_addr_log[i] !== AW'(i)) begin errors++; $display("FAIL stall_addr[%0d]: got %0d expected %0d", i, rd_addr_log[i], i); end
            checks++; if (res_user_log[i] !== UW'(9 - i)) begin errors++; $display("FAIL stall_res_user[%0d]: got %0d expected %0d", i, res_user_log[i], 9 - i); end
        end
        checks++; if (result_count !== AW'(6)) begin errors++; $display("FAIL stall_result_count: got %0d expected 6", result_count); end
        checks++; if (match_count !== AW'(6)) begin errors++; $display("FAIL stall_match_count: got %0d expected 6", match_count); end
        repeat (4) @(posedge clk);
    endtask

    task automatic test_restart_reset();
        bit hit;
        int d0, r0, b0, nr;
        for (int i = 0; i < 6; i++) labels[i] = UW'(i);
        pulse_start(6);
        sample_count = AW'(2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rd_count - rd_base >= 2) begin hit = 1'b1; break; end
            @(posedge clk); #1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL restart_issue_reached: got %0d reads expected 2", rd_count - rd_base); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        nr = rd_count - rd_base;
        for (int i = 0; i < nr && i < 32; i++) begin
            checks++; if (rd_addr_log[i] !== AW'(i)) begin errors++; $display("FAIL restart_addr[%0d]: got %0d expected %0d", i, rd_addr_log[i], i); end
        end
        d0 = done_count; r0 = res_count; b0 = busy_count;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_busy: got %b expected 0", busy); end
        checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL restart_mem_rd: got %b expected 0", bus.mem_rd); end
        checks++; if (bus.net_in_valid !== 1'b0) begin errors++; $display("FAIL restart_net_in_valid: got %b expected 0", bus.net_in_valid); end
        repeat (12) @(negedge clk);
        #1;
        checks++; if (done_count != d0) begin errors++; $display("FAIL restart_no_done: got %0d done pulses expected 0", done_count - d0); end
        checks++; if (res_count != r0) begin errors++; $display("FAIL restart_late_results: got %0d expected 0", res_count - r0); end
        checks++; if (busy_count != b0) begin errors++; $display("FAIL restart_busy_after: got %0d busy cycles expected 0", busy_count - b0); end
        checks++; if (result_count !== '0) begin errors++; $display("FAIL restart_result_count: got %0d expected 0", result_count); end
        checks++; if (match_count !== '0) begin errors++; $display("FAIL restart_match_count: got %0d expected 0", match_count); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        labels[0] = 8'd1; labels[1] = 8'd2; labels[2] = 8'd3;
        pulse_start(3);
        wait_done(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_first_done: got no done expected done"); end
        checks++; if (result_count !== AW'(3)) begin errors++; $display("FAIL b2b_first_result_count: got %0d expected 3", result_count); end
        checks++; if (match_count !== AW'(3)) begin errors++; $display("FAIL b2b_first_match_count: got %0d expected 3", match_count); end
        labels[0] = 8'd4; labels[1] = 8'd5;
        pulse_start(2);
        @(negedge clk);
        checks++; if (result_count !== '0 || match_count !== '0) begin errors++; $display("FAIL b2b_clear_at_start: got %0d/%0d expected 0/0", result_count, match_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_busy: got %b expected 1", busy); end
        wait_done(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_second_done: got no done expected done"); end
        checks++; if (res_user_log[0] !== 8'd4 || res_user_log[1] !== 8'd5) begin errors++; $display("FAIL b2b_res_users: got %0d,%0d expected 4,5", res_user_log[0], res_user_log[1]); end
        checks++; if (match_count !== AW'(2)) begin errors++; $display("FAIL b2b_match_count: got %0d expected 2", match_count); end
        checks++; if (result_count !== AW'(2)) begin errors++; $display("FAIL b2b_result_count: got %0d expected 2", result_count); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) labels[i] = '0;
        for (int i = 0; i < 3; i++) pu[i] = '0;
        test_reset();
        test_basic();
        test_zero();
        test_mismatch();
        test_stall();
        test_restart_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mnist_lut_batch_sequencer.md
MNIST_LUT_BATCH_SEQUENCER -- requirements
Module: mnist_lut_batch_sequencer

Interface
REQ-001 Parameters SHALL be USER_WIDTH, default 8, label field width; INPUT_WIDTH, default 784, pixel vector width; OUTPUT_WIDTH, default 10, class one-hot width; ADDR_WIDTH, default 14, sample memory address width.
REQ-002 Ports SHALL be as follows; the block has one clock, clk, and its reset, reset, is synchronous and active-high.
- reset  in  1  synchronous active-high reset
- clk  in  1  clock
- cke  in  1  global clock enable
- start  in  1  begin a batch (pulse)
- sample_count  in  ADDR_WIDTH  number of samples, latched on accepted start
- busy  out  1  batch in progress
- done  out  1  one-cycle end-of-batch pulse
- mem_rd  out  1  sample memory read enable
- mem_addr  out  ADDR_WIDTH  sample memory address
- mem_rdata  in  USER_WIDTH+INPUT_WIDTH  {label, pixels}; valid 1 cycle after mem_rd; held while mem_rd low
- net_cke  out  1  clock enable to the LUT network
- net_in_user  out  USER_WIDTH  label to network
- net_in_data  out  INPUT_WIDTH  pixels to network
- net_in_valid  out  1  network input valid
- net_out_user  in  USER_WIDTH  label from network
- net_out_data  in  OUTPUT_WIDTH  network class output
- net_out_valid  in  1  network output valid
- res_ready  in  1  result sink ready
- res_valid  out  1  per-sample result valid
- res_user  out  USER_WIDTH  label of the result
- res_match  out  1  classification correct
- match_count  out  ADDR_WIDTH  correct results in the current or last batch
- result_count  out  ADDR_WIDTH  results retired in the current or last batch

Function
REQ-003 The FSM SHALL have the states IDLE, ISSUE, DRAIN and DONE, with all transitions taken only in cycles where net_cke=1.
REQ-004 In IDLE, start=1 SHALL latch sample_count, clear match_count, result_count, the issue address and the in-flight counter, then go to ISSUE, or to DONE if sample_count=0.
REQ-005 start SHALL be ignored outside IDLE.
REQ-006 In ISSUE, each net_cke cycle SHALL assert mem_rd with mem_addr = issue address and then increment that address; the last address is count-1, after which the FSM goes to DRAIN.
REQ-007 net_in_valid SHALL be asserted, with {net_in_user, net_in_data} = mem_rdata, in the net_cke cycle following each read.
- net_in_valid SHALL NOT be asserted otherwise.
- net_in_user and net_in_data SHALL be don't-care when net_in_valid=0.
REQ-008 With net_cke held at 1, the latency from the start cycle SHALL be 2 cycles to the first net_in_valid.
REQ-009 net_cke SHALL equal cke AND res_ready.
- While net_cke=0, all state, counters, mem_rd, net_in_* and res_* SHALL hold their values.
- mem_rd SHALL be gated to 0 while net_cke=0.
REQ-010 The in-flight counter (width ADDR_WIDTH+1) SHALL count up on each net_in_valid and down on each net_out_valid.
- Both in the same cycle SHALL leave it unchanged.
- net_out_valid while the counter is 0 SHALL be discarded.
REQ-011 In DRAIN, when the in-flight counter is 0 and no read is pending, the FSM SHALL go to DONE.
REQ-012 DONE SHALL last exactly one cycle, assert done=1 and return to IDLE.
REQ-013 busy SHALL be 1 in ISSUE and DRAIN and 0 in IDLE and DONE.
REQ-014 On a net_cke cycle with net_out_valid=1, the block SHALL register res_valid=1 with res_user = net_out_user.
- res_match SHALL be 1 iff net_out_user < OUTPUT_WIDTH and net_out_data equals the one-hot value with bit net_out_user set.
- net_out_user >= OUTPUT_WIDTH SHALL give res_match=0.
REQ-015 Each retired result SHALL increment result_count, and also match_count when res_match=1.
- The counts SHALL NOT wrap, because they are at most count ≤ 2^ADDR_WIDTH-1.
- The counts SHALL hold their values after done until the next accepted start.
REQ-016 res_valid SHALL be a one-cycle pulse per retired result when net_cke=1, and SHALL be held while net_cke=0.

Reset
REQ-017 On reset=1 at a clk edge, regardless of cke or state, the block SHALL go to IDLE with these outputs and registers:
- busy=0, done=0, mem_rd=0, mem_addr=0
- net_in_valid=0, res_valid=0, res_match=0, res_user=0
- match_count=0, result_count=0, in-flight counter=0
REQ-018 Reset mid-batch SHALL abort the batch with no done pulse, and results arriving afterwards SHALL be discarded per REQ-010.

Structure
REQ-019 The FSM state encoding and a one-hot-of-label helper function SHALL reside in a shared package, mnist_lut_pkg.
REQ-020 The result comparison and counting SHALL be a sub-module, mnist_lut_result_checker (inputs: net_out_*, net_cke, clear; outputs: res_*, match_count, result_count).

Verification
REQ-021 sample_count=4, cke=res_ready=1, network modelled as a 3-cycle delay line with out_data = 1<<user -> mem_addr 0..3, net_in_valid first seen 2 cycles after start, done after the 4th result, match_count=4, result_count=4.
REQ-022 sample_count=0 -> done pulse 1 cycle after start, busy stays 0, no mem_rd, counts=0.
REQ-023 sample_count=5, labels 7,3,12,1,0 with the model returning the correct class for 7, 3 and 1 only -> res_match 1,1,0,1,0, match_count=3, result_count=5.
REQ-024 res_ready=0 for 4 cycles mid-ISSUE -> net_cke=0 for those cycles; mem_addr, net_in_*, res_* and the in-flight counter frozen; no sample lost or duplicated; final result_count=sample_count.
REQ-025 start re-pulsed while busy, then reset asserted after the 2nd issue -> the second start is ignored; after reset: IDLE, busy=0, counts=0, no done; late network outputs do not update the counts.
REQ-026 Back-to-back batches (3 then 2 samples, start given in the cycle after done) -> counts cleared at the second start, final match_count=2, result_count=2.
